// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial word transmitter.
// The state enum always lists PARITY; only SERIAL_TX_PARITY_EN builds use it.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int RES_W = 4;

endpackage

// File: rtl/residue_step.sv
// Combinational residue update: next = (residue*2 + bit) mod MOD.
// The current residue is always below MOD (at most 15), so the sum fits in 5 bits.
module residue_step
    import serial_tx_pkg::*;
#(
    parameter int MOD = 4
) (
    input  logic [RES_W-1:0] i_residue,
    input  logic             i_bit,
    output logic [RES_W-1:0] o_residue
);

    logic [4:0] w_sum;
    logic [4:0] w_mod;

    assign w_sum     = {i_residue, 1'b0} + {4'b0000, i_bit};
    assign w_mod     = w_sum % 5'(MOD);
    assign o_residue = w_mod[RES_W-1:0];

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, MSB first, with a running residue of the bits sent.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit to every frame.
//
// Handshake: a word is taken on the rising edge where in_valid and in_ready are both 1;
// in_valid while in_ready is 0 is dropped, with nothing held for later.
module serial_word_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             done,
    output logic [RES_W-1:0] residue,
    output state_t           o_dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-2:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_ser_last;
    logic             r_done;
    logic [RES_W-1:0] r_residue;
`ifdef SERIAL_TX_PARITY_EN
    logic             r_parity;
`endif

    logic [RES_W-1:0] w_res_next;
    logic             w_accept;
    logic             w_last_bit;

    residue_step #(.MOD(MOD)) u_residue_step (
        .i_residue (r_residue),
        .i_bit     (r_ser_out),
        .o_residue (w_res_next)
    );

    assign w_accept   = in_valid & r_in_ready;
    assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

    // r_ser_out already holds the MSB on capture; r_shift keeps the remaining bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
            r_done      <= 1'b0;
            r_residue   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_ser_out   <= 1'b0;
                    r_ser_valid <= 1'b0;
                    r_ser_last  <= 1'b0;
                    if (w_accept) begin
                        r_state     <= SHIFT;
                        r_in_ready  <= 1'b0;
                        r_shift     <= in_data[WIDTH-2:0];
                        r_ser_out   <= in_data[WIDTH-1];
                        r_ser_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_residue   <= '0;
`ifdef SERIAL_TX_PARITY_EN
                        r_parity    <= ^in_data;
`endif
                    end
                end
                SHIFT: begin
                    r_residue <= w_res_next;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (w_last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
                        r_state    <= PARITY;
                        r_ser_out  <= r_parity;
                        r_ser_last <= 1'b1;
`else
                        r_state     <= IDLE;
                        r_ser_out   <= 1'b0;
                        r_ser_valid <= 1'b0;
                        r_ser_last  <= 1'b0;
                        r_done      <= 1'b1;
                        r_in_ready  <= 1'b1;
`endif
                    end else begin
                        r_shift   <= r_shift << 1;
                        r_ser_out <= r_shift[WIDTH-2];
`ifdef SERIAL_TX_PARITY_EN
                        r_ser_last <= 1'b0;
`else
                        r_ser_last <= (r_cnt == CNT_W'(WIDTH - 2));
`endif
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    r_state     <= IDLE;
                    r_ser_out   <= 1'b0;
                    r_ser_valid <= 1'b0;
                    r_ser_last  <= 1'b0;
                    r_done      <= 1'b1;
                    r_in_ready  <= 1'b1;
                end
`endif
                default: begin
                    r_state     <= IDLE;
                    r_ser_out   <= 1'b0;
                    r_ser_valid <= 1'b0;
                    r_ser_last  <= 1'b0;
                    r_done      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign ser_out     = r_ser_out;
    assign ser_valid   = r_ser_valid;
    assign ser_last    = r_ser_last;
    assign done        = r_done;
    assign residue     = r_residue;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: two instances (MOD=4 and MOD=3) share stimulus; residues are
// predicted as (value of the bits sent so far) mod MOD, frames as plain bit lists.
module tb_serial_word_tx;
    import serial_tx_pkg::*;

    localparam int W = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME_LEN = W + (PAR ? 1 : 0);

    typedef struct {
        int b;
        int last;
        int ra;
        int rb;
    } exp_t;

    typedef struct {
        int ra;
        int rb;
    } fin_t;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready_a, ser_out_a, ser_valid_a, ser_last_a, done_a;
    logic             in_ready_b, ser_out_b, ser_valid_b, ser_last_b, done_b;
    logic [RES_W-1:0] residue_a, residue_b;
    state_t           dbg_a, dbg_b;

    exp_t exp_q[$];
    fin_t fin_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_caps = 0;
    int   n_intended = 0;
    int   cyc = 0;
    int   prev_last = 0;
    int   hold_a = 0;
    int   hold_b = 0;

    serial_word_tx #(.WIDTH(W), .MOD(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .ser_out(ser_out_a), .ser_valid(ser_valid_a),
        .ser_last(ser_last_a), .done(done_a), .residue(residue_a), .o_dbg_state(dbg_a)
    );

    serial_word_tx #(.WIDTH(W), .MOD(3)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .ser_out(ser_out_b), .ser_valid(ser_valid_b),
        .ser_last(ser_last_b), .done(done_b), .residue(residue_b), .o_dbg_state(dbg_b)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event, expected none (t=%0t)", name, $time);
    endtask

    // ---------------- reference model: push the whole frame on capture ----------------
    always @(posedge clk) begin
        if (reset && in_valid && in_ready_a) begin
            exp_t e;
            fin_t f;
            n_caps++;
            for (int i = W - 1; i >= 0; i--) begin
                e.b    = int'(in_data[i]);
                e.last = (i == 0 && !PAR) ? 1 : 0;
                e.ra   = (int'(in_data) >> (i + 1)) % 4;
                e.rb   = (int'(in_data) >> (i + 1)) % 3;
                exp_q.push_back(e);
            end
            if (PAR) begin
                e.b    = $countones(in_data) % 2;
                e.last = 1;
                e.ra   = int'(in_data) % 4;
                e.rb   = int'(in_data) % 3;
                exp_q.push_back(e);
            end
            f.ra = int'(in_data) % 4;
            f.rb = int'(in_data) % 3;
            fin_q.push_back(f);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            prev_last = 0;
            hold_a    = 0;
            hold_b    = 0;
            exp_q.delete();
            fin_q.delete();
        end else begin
            check("done_timing", int'(done_a), prev_last);
            if (ser_valid_a) begin
                check("ready_busy", int'(in_ready_a), 0);
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_bit");
                    prev_last = 0;
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ser_out", int'(ser_out_a), e.b);
                    check("ser_last", int'(ser_last_a), e.last);
                    check("res_run_mod4", int'(residue_a), e.ra);
                    check("res_run_mod3", int'(residue_b), e.rb);
                    prev_last = e.last;
                end
            end else begin
                prev_last = 0;
                check("idle_ser_out", int'(ser_out_a), 0);
                check("idle_ser_last", int'(ser_last_a), 0);
                if (done_a) begin
                    check("ready_done", int'(in_ready_a), 1);
                    if (fin_q.size() == 0) begin
                        note_fail("unexpected_done");
                    end else begin
                        fin_t f;
                        f = fin_q.pop_front();
                        check("res_final_mod4", int'(residue_a), f.ra);
                        check("res_final_mod3", int'(residue_b), f.rb);
                        hold_a = f.ra;
                        hold_b = f.rb;
                    end
                end else begin
                    check("res_hold_mod4", int'(residue_a), hold_a);
                    check("res_hold_mod3", int'(residue_b), hold_b);
                end
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic wait_ready();
        int t = 0;
        while (!in_ready_a && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) note_fail("ready_timeout");
    endtask

    task automatic send_word(input logic [W-1:0] d);
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        n_intended++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c1;
        int c2;
        int t;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #1 reset = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready_a), 0);
        check("rst_ser_valid", int'(ser_valid_a), 0);
        check("rst_ser_out", int'(ser_out_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_residue", int'(residue_a), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", int'(in_ready_a), 1);
        check("post_rst_residue", int'(residue_a), 0);

        // directed words
        send_word(4'b1011);
        send_word(4'b0000);
        send_word(4'b1111);
        idle_cycles(2);

        // in_valid held high: second capture must land in the done cycle
        in_valid = 1'b1;
        in_data  = 4'b1100;
        wait_ready();
        c1 = cyc;
        @(posedge clk);
        #1;
        in_data = 4'b0011;
        n_intended += 2;
        wait_ready();
        c2 = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_gap", c2 - c1, FRAME_LEN + 1);

        // pulses of in_valid while a frame is shifting are dropped
        send_word(4'b0110);
        for (int i = 0; i < W - 1; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            idle_cycles($urandom_range(0, 3));
            send_word(W'($urandom));
        end

        // reset in the middle of a frame
        send_word(4'b0110);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_ser_valid", int'(ser_valid_a), 0);
        check("midrst_ser_out", int'(ser_out_a), 0);
        check("midrst_ser_last", int'(ser_last_a), 0);
        check("midrst_in_ready", int'(in_ready_a), 0);
        check("midrst_done", int'(done_a), 0);
        check("midrst_res_mod4", int'(residue_a), 0);
        check("midrst_res_mod3", int'(residue_b), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", int'(in_ready_a), 1);
        send_word(4'b1011);
        send_word(4'b1001);

        // drain
        t = 0;
        while ((exp_q.size() != 0 || fin_q.size() != 0) && t < 200) begin
            @(posedge clk);
            t++;
        end
        idle_cycles(3);
        check("drain_bits", exp_q.size(), 0);
        check("drain_frames", fin_q.size(), 0);
        check("capture_count", n_caps, n_intended);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning data word width in bits (2..16).
REQ-002 SHALL have parameter MOD, default 4, meaning residue modulus (2..15).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  meaning a word is offered on in_data.
REQ-006 SHALL have port in_data  input  WIDTH  meaning the parallel word to serialize.
REQ-007 SHALL have port in_ready  output  1  meaning the block accepts a word this cycle.
REQ-008 SHALL have port ser_out  output  1  meaning the serial data bit, MSB first.
REQ-009 SHALL have port ser_valid  output  1  meaning ser_out carries a frame bit this cycle.
REQ-010 SHALL have port ser_last  output  1  meaning the final bit of the current frame.
REQ-011 SHALL have port done  output  1  meaning one-cycle pulse after a frame completes.
REQ-012 SHALL have port residue  output  4  meaning the value of data bits sent so far, mod MOD.

Function
REQ-013 SHALL implement states IDLE, SHIFT, PARITY, with all outputs registered.
REQ-014 In IDLE, in_ready SHALL be 1; in SHIFT and PARITY it SHALL be 0.
REQ-015 Handshake: a word SHALL be captured at the edge where in_valid=1 and in_ready=1; in_valid with in_ready=0 SHALL be ignored, with no queuing.
REQ-016 On capture, the block SHALL enter SHIFT and clear residue to 0 and the bit counter to 0.
REQ-017 In SHIFT, it SHALL present one bit per cycle, MSB first, with ser_valid=1, for exactly WIDTH cycles.
REQ-018 First bit latency SHALL be one cycle: the MSB appears in the cycle after the accepting edge.
REQ-019 At the end of each SHIFT cycle, residue SHALL update as residue = (residue*2 + ser_out) mod MOD, computed without overflow in 5-bit intermediate width.
REQ-020 After the WIDTH-th bit, the block SHALL go to PARITY when enabled (REQ-027), otherwise to IDLE.
REQ-021 ser_last SHALL be 1 on the final frame bit only: the LSB without parity, the parity bit with parity.
REQ-022 done SHALL pulse for exactly one cycle, in the first IDLE cycle after the frame, with residue holding the final value.
REQ-023 residue SHALL hold its final value in IDLE until the next capture.
REQ-024 ser_out and ser_valid SHALL be 0 in IDLE.
REQ-025 Back-to-back: a capture in the done cycle SHALL be legal, giving a minimum gap of one idle cycle between frames.

Reset
REQ-026 Reset low SHALL asynchronously force IDLE, abandon any frame, and set in_ready=0 while asserted; after release, in_ready=1, and ser_out, ser_valid, ser_last, done, residue and the bit counter SHALL be 0.

Configuration
REQ-027 With macro SERIAL_TX_PARITY_EN defined, the frame SHALL append one PARITY cycle carrying even parity (XOR of all data bits), with ser_valid=1 and no residue update; without it, the PARITY state and its logic SHALL be absent and frames SHALL be WIDTH bits.

Structure
REQ-028 Package serial_tx_pkg SHALL hold the state enum (IDLE, SHIFT, PARITY) and the residue width constant RES_W=4.
REQ-029 Sub-module residue_step SHALL compute the combinational next residue (REQ-019) from the current residue, the bit and MOD.
REQ-030 The bit counter SHALL be $clog2(WIDTH+1) bits wide and wrap-free.

Verification
REQ-031 WIDTH=4, MOD=4, in_data=4'b1011 accepted -> ser_out 1,0,1,1 on cycles 1..4, ser_last on cycle 4, done on cycle 5, residue=3.
REQ-032 WIDTH=4, MOD=3, in_data=4'b1011 -> same bit sequence and residue=2 at done; in_data=4'b0000 -> residue=0.
REQ-033 SERIAL_TX_PARITY_EN defined, in_data=4'b1011 -> bits 1,0,1,1,1 with ser_last on bit 5, done on cycle 6, residue=3.
REQ-034 in_valid held high with words 4'b1100 then 4'b0011 -> second capture in the done cycle, giving exactly one idle cycle between frames; in_valid pulses during SHIFT are ignored.
REQ-035 reset driven low at cycle 2 of a frame -> outputs go to 0 immediately, before any clock edge; after release in_ready=1 and the next frame is correct.
